key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//  Conditions raw DE2 pushbuttons (KEY[3:0], active-low, bouncing, asynchronous) into
//  clean synchronous controls for the counter/load datapath that feeds the BCD/7-seg stages.
//  Per key it provides a debounced level, one-cycle press and release pulses, and an
//  optional hold-to-repeat pulse train.
//  The counter's step and load inputs consume these pulses as clock enables.
//  Raw KEY lines are not used as clocks.
// PARAMETERS
//  N_KEYS           4          number of independent key channels
//  DEBOUNCE_CYCLES  1000000    consecutive stable cycles needed to accept a change (20 ms @ 50 MHz)
//  REPEAT_DELAY     25000000   cycles from press to first repeat pulse; 0 disables repeat
//  REPEAT_RATE      5000000    cycles between subsequent repeat pulses (must be >=1)
//  CNT_W            25         width of debounce and repeat timers (>= clog2 of the largest count)
// PORTS
//  CLOCK_50     in   1       system clock, 50 MHz, rising edge
//  reset        in   1       asynchronous, active-low reset
//  KEY          in   N_KEYS  raw pushbuttons, 0 = pressed, asynchronous
//  key_level    out  N_KEYS  debounced state, 1 = pressed
//  key_press    out  N_KEYS  1-cycle pulse when key_level rises
//  key_release  out  N_KEYS  1-cycle pulse when key_level falls
//  key_repeat   out  N_KEYS  1-cycle pulse train while held (auto-repeat)
// BEHAVIOUR
//  Reset (reset=0, async): sync flops = 1 (released); key_level, key_press, key_release
//   and key_repeat = 0; all timers = 0; repeat FSM = IDLE. All outputs are registered.
//  Sync: 2-flop synchronizer per key; invert after sync (s = ~KEY synced, 1 = pressed).
//  Debounce, per key, each edge:
//   - s == key_level: counter cleared.
//   - s != key_level and counter < DEBOUNCE_CYCLES-1: counter increments.
//   - s != key_level and counter == DEBOUNCE_CYCLES-1: key_level toggles; counter cleared.
//  Latency: key_level changes on the (DEBOUNCE_CYCLES+2)th rising edge.
//   Edge 1 is the first edge that samples the new raw value.
//   Any bounce back before then restarts the count.
//  key_press / key_release: asserted on the same edge key_level rises / falls.
//   High for exactly 1 cycle. Never both at once on one key.
//  Repeat FSM per key: IDLE -> DELAY -> REPEAT.
//   - IDLE -> DELAY on the key_level rise edge; timer cleared.
//   - DELAY: timer increments; at timer == REPEAT_DELAY-1, key_repeat pulses,
//     timer clears, go to REPEAT.
//   - REPEAT: timer increments; at timer == REPEAT_RATE-1, key_repeat pulses and timer clears.
//   - Any state -> IDLE on the key_level fall edge. No repeat pulse is issued on that edge.
//   - First repeat arrives REPEAT_DELAY edges after the press edge,
//     then every REPEAT_RATE edges.
//   - key_press and key_repeat are never high in the same cycle.
//   - REPEAT_DELAY == 0: FSM stays IDLE; key_repeat is constant 0.
//  Channels are fully independent; simultaneous events on different keys are all reported
//   in the same cycle.
//  Timers saturate, never wrap. A key held indefinitely keeps repeating at REPEAT_RATE.
//  Reset mid-operation: all state returns to reset values at once, with no pulses.
//   A key held through reset release is treated as a new press.
//   key_press fires DEBOUNCE_CYCLES+2 edges after reset deasserts (sync flops reset to released).
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_KEYS=4)
//  1. Clean press: KEY[0] 1->0 and held.
//     -> key_level[0] and key_press[0] rise on the 6th edge; key_press[0] is 1 cycle wide.
//     -> Other keys stay 0.
//  2. Bounce: KEY[1] low for 3 cycles, high for 2, then low and held.
//     -> No change during the glitch.
//     -> key_press[1] fires 6 edges after the final fall; exactly one pulse.
//  3. Release: after test 1, KEY[0] 0->1.
//     -> key_level[0] falls and key_release[0] pulses on the 6th edge; key_repeat[0] is silent.
//  4. Auto-repeat: hold KEY[2] for 30 cycles past press edge P.
//     -> key_repeat[2] pulses at P+10, P+13, P+16, ... P+28.
//     -> No pulse on the release edge.
//  5. Simultaneous keys: KEY[3:0] = 4'b0000 on the same edge.
//     -> key_press = 4'b1111 in one cycle, 6 edges later.
//  6. Reset mid-operation: KEY[2] held in REPEAT state; pulse reset low for 2 cycles.
//     -> All outputs are 0 while reset is low.
//     -> key_press[2] fires on the 6th edge after release; first repeat comes 10 edges later.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw, bouncing, active-low DE2 pushbuttons into clean
// synchronous controls: debounced level, press/release pulses and an optional
// hold-to-repeat pulse train for each key. Every output is registered.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rptState_t;

  // Terminal counts; the guarded forms keep a zero parameter from wrapping to all-ones.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_KEYS-1:0] syncA_q, syncB_q;
  logic [N_KEYS-1:0] keyPressed;
  logic [CNT_W-1:0]  dbCnt_q [N_KEYS];
  logic [CNT_W-1:0]  dbCnt_d [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;
  rptState_t         rptState_q [N_KEYS];
  rptState_t         rptState_d [N_KEYS];
  logic [CNT_W-1:0]  rptCnt_q [N_KEYS];
  logic [CNT_W-1:0]  rptCnt_d [N_KEYS];

  // Timers stop at their maximum instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_W'(1);
  endfunction

  // Two-flop synchronizer; resets to the released (high) level so a key held
  // through reset is seen as a fresh press.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      syncA_q <= '1;
      syncB_q <= '1;
    end else begin
      syncA_q <= KEY;
      syncB_q <= syncA_q;
    end
  end

  assign keyPressed = ~syncB_q;

  // Debounce: accept a new level only after it has been stable long enough.
  always_comb begin
    level_d = level_q;
    for (int k = 0; k < N_KEYS; k++) begin
      dbCnt_d[k] = dbCnt_q[k];
      if (keyPressed[k] == level_q[k]) begin
        dbCnt_d[k] = '0;
      end else if (dbCnt_q[k] >= DB_LAST) begin
        level_d[k] = ~level_q[k];
        dbCnt_d[k] = '0;
      end else begin
        dbCnt_d[k] = satInc(dbCnt_q[k]);
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Repeat FSM next-state: delay after the press, then a steady pulse train until release.
  always_comb begin
    repeat_d = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      rptState_d[k] = rptState_q[k];
      rptCnt_d[k]   = rptCnt_q[k];
      if (REPEAT_DELAY == 0) begin
        rptState_d[k] = RPT_IDLE;
        rptCnt_d[k]   = '0;
      end else if (release_d[k]) begin
        rptState_d[k] = RPT_IDLE;
        rptCnt_d[k]   = '0;
      end else begin
        case (rptState_q[k])
          RPT_IDLE: begin
            if (press_d[k]) begin
              rptState_d[k] = RPT_DELAY;
              rptCnt_d[k]   = '0;
            end
          end
          RPT_DELAY: begin
            if (rptCnt_q[k] >= RD_LAST) begin
              repeat_d[k]   = 1'b1;
              rptCnt_d[k]   = '0;
              rptState_d[k] = RPT_REPEAT;
            end else begin
              rptCnt_d[k] = satInc(rptCnt_q[k]);
            end
          end
          RPT_REPEAT: begin
            if (rptCnt_q[k] >= RR_LAST) begin
              repeat_d[k] = 1'b1;
              rptCnt_d[k] = '0;
            end else begin
              rptCnt_d[k] = satInc(rptCnt_q[k]);
            end
          end
          default: begin
            rptState_d[k] = RPT_IDLE;
            rptCnt_d[k]   = '0;
          end
        endcase
      end
    end
  end

  // Debounce counters and the registered level/pulse outputs.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_KEYS; k++) dbCnt_q[k] <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) dbCnt_q[k] <= dbCnt_d[k];
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Repeat FSM state and timer registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_KEYS; k++) begin
        rptState_q[k] <= RPT_IDLE;
        rptCnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        rptState_q[k] <= rptState_d[k];
        rptCnt_q[k]   <= rptCnt_d[k];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;

endmodule
